diferential_muxpga_grid: RTL and testbench
==========================================

DIFERENTIAL_MUXPGA_GRID -- requirements
Module: diferential_muxpga_grid

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of physical cell rows; a virtual row 0 above them is driven by din.
REQ-002 SHALL have parameter COLS, default 3: cells per row.
REQ-003 SHALL have parameter W, default 4: cell data width; legal range is W >= 4.
REQ-004 SHALL have parameter CNT_W, default 8: step counter width; legal range is CNT_W >= W.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cmd, input, 2 bits: 0 = CFG_SHIFT, 1 = RUN, 2 = STEP, 3 = LOAD_STEPS.
REQ-008 SHALL have port din, input, W bits: configuration word source (din[3:0]), row-0 data and step count.
REQ-009 SHALL have port dout, output, 2W bits: readout.
REQ-010 SHALL have port done, output, 1 bit, registered: STEP budget exhausted.
REQ-011 SHALL have port cfg_par, output, 1 bit, registered: configuration parity (see Configuration).

Function
REQ-012 Configuration chain SHALL hold N = 2*ROWS*COLS words of 4 bits each.
REQ-013 While cmd=0, word[0] SHALL load din[3:0] and word[i] SHALL load word[i-1] each cycle; otherwise every word SHALL hold.
REQ-014 Cell (r,c), with r=1..ROWS, SHALL use routing word k=2*((r-1)*COLS+c) and function word k+1.
REQ-015 Routing word bits [1:0] SHALL select in1 and bits [3:2] SHALL select in2 with: 0 = q[r-1][c]; 1 = q[r-1][c-1]; 2 = q[r][c-1]; 3 = q[r][c+1].
REQ-016 Row indices SHALL wrap modulo ROWS+1 and column indices SHALL wrap modulo COLS; q of row 0 SHALL equal din.
REQ-017 Function word bits [1:0] SHALL select f: 0 = in1|in2; 1 = in1&in2; 2 = in1^in2; 3 = in1. Bit 2 set SHALL bitwise-invert f. Bit 3 is reserved and SHALL be ignored.
REQ-018 Each cell SHALL hold a W-bit register q; q SHALL load f when the fabric is enabled and hold otherwise. Cell outputs SHALL be registered only, with no combinational path through a cell.
REQ-019 The fabric SHALL be enabled when cmd=1, or when cmd=2 and step_cnt != 0.
REQ-020 With cmd=2 and step_cnt != 0: step_cnt SHALL decrement by 1; on the cycle it goes 1 -> 0, done SHALL be set to 1.
REQ-021 With cmd=2 and step_cnt = 0: the fabric SHALL hold and done SHALL hold.
REQ-022 With cmd=3: step_cnt SHALL load din zero-extended to CNT_W and done SHALL clear to 0; din=0 SHALL leave done=0 and allow no further STEP progress.
REQ-023 In RUN, step_cnt and done SHALL hold.
REQ-024 dout SHALL be combinational from registers: for cmd 1 or 2, dout = {q[ROWS][0], q[ROWS][COLS-1]}; for cmd 0 or 3, dout = {word[N-1], zeros}.
REQ-025 A value presented on din SHALL reach row r after r enabled edges, so fabric latency is ROWS enabled cycles.

Reset
REQ-026 reset=0 SHALL immediately, without a clock edge, clear all configuration words, all cell q, step_cnt, done and cfg_par to 0.
REQ-027 Reset asserted mid-STEP or mid-shift SHALL abort the operation with no residual state.
REQ-028 Release SHALL take effect at the first rising clk edge after reset returns to 1.

Configuration
REQ-029 Macro MUXPGA_GRID_CFG_PARITY_EN SHALL control configuration parity.
REQ-030 With MUXPGA_GRID_CFG_PARITY_EN defined: cfg_par SHALL be registered as the XOR of all 4N chain bits as they stand after each clock edge, updating one cycle after any chain change.
REQ-031 With MUXPGA_GRID_CFG_PARITY_EN undefined: cfg_par SHALL be constant 0 and no parity logic SHALL be built.

Verification
All scenarios use the defaults ROWS=4, COLS=3, W=4, CNT_W=8, giving N=24.
REQ-032 Reset: reset=0 then 1 with cmd=1 and din=0 -> dout=8'h00, done=0, cfg_par=0.
REQ-033 Shift: 24 CFG_SHIFT cycles with din=1,2,...,15,1,...,9 -> dout=8'h10; one further shift -> dout=8'h20; with parity enabled, cfg_par matches the XOR of all 24 loaded words.
REQ-034 Pass-through: all words 0, then cmd=1 with din=4'hA -> dout=8'h00 for edges 1-3 and 8'hAA from the 4th edge.
REQ-035 Invert chain: all function words 4'h4 and all routing words 0, cmd=1 with din=0 for 4 edges -> rows are F,0,F,0 and dout=8'h00; din=4'hF for 4 edges -> dout=8'hFF.
REQ-036 Step budget: cmd=3 with din=2, then cmd=2 with din=5 for 6 cycles -> done rises after the 2nd edge, rows 1-2 = 5, dout stays 8'h00; cmd=3 with din=2 clears done.
REQ-037 Async abort: step_cnt=5 with cmd=2 and reset pulsed low between edges -> dout=0 and done=0 before the next edge; a following cmd=2 gives no fabric update.

Source files
------------

// File: rtl/diferential_muxpga_grid.sv
// Mux-routed PGA grid: a 4-bit configuration shift chain programs a ROWS x COLS array of
// registered logic cells fed by din. Optional configuration parity: MUXPGA_GRID_CFG_PARITY_EN.
module diferential_muxpga_grid #(
    parameter int ROWS  = 4,
    parameter int COLS  = 3,
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cmd,
    input  logic [W-1:0]     din,
    output logic [2*W-1:0]   dout,
    output logic             done,
    output logic             cfg_par
);

    localparam int N = 2 * ROWS * COLS;

    localparam logic [1:0] CMD_CFG_SHIFT  = 2'd0;
    localparam logic [1:0] CMD_RUN        = 2'd1;
    localparam logic [1:0] CMD_STEP       = 2'd2;
    localparam logic [1:0] CMD_LOAD_STEPS = 2'd3;

    logic [3:0]       cfg_q  [N];
    logic [3:0]       cfg_d  [N];
    logic [W-1:0]     cell_q [ROWS][COLS];
    logic [W-1:0]     cell_d [ROWS][COLS];
    logic [W-1:0]     grid   [ROWS+1][COLS];
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             done_q, done_d;
    logic             fabric_en;

    function automatic logic [W-1:0] route(
        input logic [1:0]   sel,
        input logic [W-1:0] up,
        input logic [W-1:0] up_left,
        input logic [W-1:0] left,
        input logic [W-1:0] right
    );
        logic [W-1:0] v;
        case (sel)
            2'd0:    v = up;
            2'd1:    v = up_left;
            2'd2:    v = left;
            default: v = right;
        endcase
        return v;
    endfunction

    // Bit 3 of the function word is reserved, so only [2:0] is passed in.
    function automatic logic [W-1:0] cell_func(
        input logic [2:0]   fw,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W-1:0] f;
        case (fw[1:0])
            2'd0:    f = a | b;
            2'd1:    f = a & b;
            2'd2:    f = a ^ b;
            default: f = a;
        endcase
        return fw[2] ? ~f : f;
    endfunction

    assign fabric_en = (cmd == CMD_RUN) ||
                       ((cmd == CMD_STEP) && (step_cnt_q != '0));

    always_comb begin
        cfg_d = cfg_q;
        if (cmd == CMD_CFG_SHIFT) begin
            cfg_d[0] = din[3:0];
            for (int i = 1; i < N; i++) begin
                cfg_d[i] = cfg_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Row 0 of the grid is the virtual din row; rows 1..ROWS are the cell registers.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            grid[0][c] = din;
            for (int r = 1; r <= ROWS; r++) begin
                grid[r][c] = cell_q[r-1][c];
            end
        end
    end

    for (genvar r = 1; r <= ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K  = 2 * ((r - 1) * COLS + c);
            localparam int CL = (c + COLS - 1) % COLS;
            localparam int CR = (c + 1) % COLS;

            logic [W-1:0] in1;
            logic [W-1:0] in2;

            assign in1 = route(cfg_q[K][1:0], grid[r-1][c], grid[r-1][CL],
                               grid[r][CL], grid[r][CR]);
            assign in2 = route(cfg_q[K][3:2], grid[r-1][c], grid[r-1][CL],
                               grid[r][CL], grid[r][CR]);
            assign cell_d[r-1][c] = fabric_en ? cell_func(cfg_q[K+1][2:0], in1, in2)
                                              : cell_q[r-1][c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cell_q[r][c] <= '0;
                end
            end
        end else begin
            cell_q <= cell_d;
        end
    end

    // An empty budget leaves done untouched so a finished STEP run stays flagged.
    always_comb begin
        step_cnt_d = step_cnt_q;
        done_d     = done_q;
        case (cmd)
            CMD_STEP: begin
                if (step_cnt_q != '0) begin
                    step_cnt_d = step_cnt_q - CNT_W'(1);
                    if (step_cnt_q == CNT_W'(1)) begin
                        done_d = 1'b1;
                    end
                end
            end
            CMD_LOAD_STEPS: begin
                step_cnt_d = CNT_W'(din);
                done_d     = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            done_q     <= done_d;
        end
    end

    assign done = done_q;

    always_comb begin
        dout = '0;
        if ((cmd == CMD_RUN) || (cmd == CMD_STEP)) begin
            dout = {cell_q[ROWS-1][0], cell_q[ROWS-1][COLS-1]};
        end else begin
            dout[2*W-1 -: 4] = cfg_q[N-1];
        end
    end

`ifdef MUXPGA_GRID_CFG_PARITY_EN
    logic par_d, par_q;

    always_comb begin
        par_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            par_d = par_d ^ (^cfg_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign cfg_par = par_q;
`else
    assign cfg_par = 1'b0;
`endif

endmodule

// File: tb/tb_diferential_muxpga_grid.sv
// Scoreboard bench for diferential_muxpga_grid: directed scenarios plus a random run
// checked against a behavioural model of the chain, fabric and step counter.
module tb_diferential_muxpga_grid;

    localparam int ROWS  = 4;
    localparam int COLS  = 3;
    localparam int W     = 4;
    localparam int CNT_W = 8;
    localparam int N     = 2 * ROWS * COLS;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     cmd;
    logic [W-1:0]   din;
    logic [2*W-1:0] dout;
    logic           done;
    logic           cfg_par;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];

    logic [3:0] cfg_m [N];
    logic [3:0] q_m   [ROWS+1][COLS];
    int         step_m;
    logic       done_m;
    logic       par_m;

    diferential_muxpga_grid #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd),
        .din     (din),
        .dout    (dout),
        .done    (done),
        .cfg_par (cfg_par)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) cfg_m[i] = 4'h0;
        for (int r = 0; r <= ROWS; r++)
            for (int c = 0; c < COLS; c++) q_m[r][c] = 4'h0;
        step_m = 0;
        done_m = 1'b0;
        par_m  = 1'b0;
    endtask

    function automatic logic [3:0] pick(input int r, input int c, input logic [1:0] s);
        case (s)
            2'd0:    return q_m[r-1][c];
            2'd1:    return q_m[r-1][(c + COLS - 1) % COLS];
            2'd2:    return q_m[r][(c + COLS - 1) % COLS];
            default: return q_m[r][(c + 1) % COLS];
        endcase
    endfunction

    task automatic model_edge(input logic [1:0] c_in, input logic [3:0] d_in);
        logic [3:0] nq [ROWS+1][COLS];
        logic [3:0] rw, fw, a, b, f;
        int k;
        bit en;
        en = (c_in == 2'd1) || ((c_in == 2'd2) && (step_m != 0));
        for (int c = 0; c < COLS; c++) q_m[0][c] = d_in;
        nq = q_m;
        if (en) begin
            for (int r = 1; r <= ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    k  = 2 * ((r - 1) * COLS + c);
                    rw = cfg_m[k];
                    fw = cfg_m[k+1];
                    a  = pick(r, c, rw[1:0]);
                    b  = pick(r, c, rw[3:2]);
                    case (fw[1:0])
                        2'd0:    f = a | b;
                        2'd1:    f = a & b;
                        2'd2:    f = a ^ b;
                        default: f = a;
                    endcase
                    if (fw[2]) f = ~f;
                    nq[r][c] = f;
                end
            end
        end
        q_m = nq;
        par_m = 1'b0;
        for (int i = 0; i < N; i++) par_m = par_m ^ (^cfg_m[i]);
        if (c_in == 2'd0) begin
            for (int i = N - 1; i > 0; i--) cfg_m[i] = cfg_m[i-1];
            cfg_m[0] = d_in;
        end
        if ((c_in == 2'd2) && (step_m != 0)) begin
            if (step_m == 1) done_m = 1'b1;
            step_m = step_m - 1;
        end else if (c_in == 2'd3) begin
            step_m = int'(d_in);
            done_m = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_dout(input logic [1:0] c_in);
        if ((c_in == 2'd1) || (c_in == 2'd2)) return {q_m[ROWS][0], q_m[ROWS][COLS-1]};
        return {cfg_m[N-1], 4'h0};
    endfunction

    task automatic cyc(input logic [1:0] c_in, input logic [3:0] d_in);
        cmd = c_in;
        din = d_in;
        @(posedge clk);
        model_edge(c_in, d_in);
        #1;
    endtask

    task automatic do_reset();
        cmd = 2'd1;
        din = 4'h0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        cmd   = 2'd1;
        din   = 4'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        total++;
        if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if (cfg_par !== 1'b0) begin bad++; $display("FAIL reset_cfg_par got=%b want=0", cfg_par); end
        #1 reset = 1'b1;
        model_reset();
        exp_q.push_back(8'h00);
        cyc(2'd1, 4'h0);
        e = exp_q.pop_front();
        total++;
        if (dout !== e) begin bad++; $display("FAIL release_dout got=%h want=%h", dout, e); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL release_done got=%b want=0", done); end
    endtask

    task automatic test_shift();
        logic [7:0] e;
        logic [3:0] x;
        logic       par_exp;
        do_reset();
        x = 4'h0;
        for (int j = 0; j < N; j++) begin
            x = x ^ 4'((j % 15) + 1);
            cyc(2'd0, 4'((j % 15) + 1));
        end
        exp_q.push_back(8'h10);
        e = exp_q.pop_front();
        total++;
        if (dout !== e) begin bad++; $display("FAIL shift24_dout got=%h want=%h", dout, e); end
        cyc(2'd3, 4'h0);
`ifdef MUXPGA_GRID_CFG_PARITY_EN
        par_exp = ^x;
`else
        par_exp = 1'b0;
`endif
        total++;
        if (cfg_par !== par_exp) begin bad++; $display("FAIL shift_cfg_par got=%b want=%b", cfg_par, par_exp); end
        exp_q.push_back(8'h20);
        cyc(2'd0, 4'h3);
        e = exp_q.pop_front();
        total++;
        if (dout !== e) begin bad++; $display("FAIL shift25_dout got=%h want=%h", dout, e); end
    endtask

    task automatic test_passthru();
        logic [7:0] e;
        do_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 4; i++) begin
            cyc(2'd1, 4'hA);
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL passthru_edge%0d got=%h want=%h", i + 1, dout, e); end
        end
    endtask

    task automatic test_invert();
        logic [7:0] e;
        do_reset();
        for (int j = 0; j < N; j++) cyc(2'd0, (j % 2 == 0) ? 4'h4 : 4'h0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) begin
            cyc(2'd1, (i < 4) ? 4'h0 : 4'hF);
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL invert_edge%0d got=%h want=%h", i + 1, dout, e); end
        end
    endtask

    task automatic test_step();
        logic [7:0] e;
        logic       de;
        do_reset();
        cyc(2'd3, 4'h2);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(8'h00);
            cyc(2'd2, 4'h5);
            e  = exp_q.pop_front();
            de = (i == 0) ? 1'b0 : 1'b1;
            total++;
            if (dout !== e) begin bad++; $display("FAIL step_dout_edge%0d got=%h want=%h", i + 1, dout, e); end
            total++;
            if (done !== de) begin bad++; $display("FAIL step_done_edge%0d got=%b want=%b", i + 1, done, de); end
        end
        cyc(2'd3, 4'h2);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL step_reload_done got=%b want=0", done); end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 2; i++) begin
            cyc(2'd1, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL step_rows_run%0d got=%h want=%h", i + 1, dout, e); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) cyc(2'd1, 4'hF);
        cyc(2'd3, 4'h5);
        cmd = 2'd2;
        din = 4'hF;
        #1;
        total++;
        if (dout !== 8'hFF) begin bad++; $display("FAIL abort_pre_dout got=%h want=ff", dout); end
        #1 reset = 1'b0;
        #1;
        total++;
        if (dout !== 8'h00) begin bad++; $display("FAIL abort_dout got=%h want=00", dout); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        model_reset();
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h00);
            cyc(2'd2, 4'hF);
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL abort_step%0d_dout got=%h want=%h", i + 1, dout, e); end
        end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL abort_post_done got=%b want=0", done); end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic [1:0] c;
        logic [3:0] d;
        logic       pe;
        int         sel;
        do_reset();
        for (int j = 0; j < N; j++) cyc(2'd0, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            c   = (sel == 0) ? 2'd0 : (sel < 5) ? 2'd1 : (sel < 8) ? 2'd2 : 2'd3;
            d   = 4'($urandom_range(0, 15));
            cyc(c, d);
            exp_q.push_back(model_dout(c));
`ifdef MUXPGA_GRID_CFG_PARITY_EN
            pe = par_m;
`else
            pe = 1'b0;
`endif
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL rand%0d_dout cmd=%0d got=%h want=%h", i, c, dout, e); end
            total++;
            if (done !== done_m) begin bad++; $display("FAIL rand%0d_done got=%b want=%b", i, done, done_m); end
            total++;
            if (cfg_par !== pe) begin bad++; $display("FAIL rand%0d_cfg_par got=%b want=%b", i, cfg_par, pe); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_shift();
        test_passthru();
        test_invert();
        test_step();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
